mult_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one pipelined unsigned multiplier among NUM_REQ requesters.

---
 rtl/mult_rr_scheduler.sv | 97 +++++++++
 tb/tb_mult_rr_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// Round-robin front end for one shared pipelined unsigned multiplier.
// Grants one requester per cycle, tags each issue, and returns products with the requester index.
module mult_rr_scheduler #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int NUM_REQ     = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_result,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       busy
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] cand;
    logic [ID_W:0]   cand_sum;
    logic            found;
    logic            transfer;

    logic [PIPE_STAGES-1:0]           tag_v;
    logic [PIPE_STAGES-1:0][ID_W-1:0] tag_id;

    // Search starts at rr_ptr and wraps modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Handshake: a transfer happens on the edge where req_valid[i] & req_ready[i];
    // ready is one-hot (or zero), never looks at operands, and requesters hold until accepted.
    assign transfer  = en & found;
    assign req_ready = transfer ? (NUM_REQ'(1) << winner) : '0;
    assign ptr_next  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // Operand bus stays at zero when nothing issues to keep the multiplier inputs quiet.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (transfer && (winner == ID_W'(i))) begin
                mul_a = req_a[i*WIDTH +: WIDTH];
                mul_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= transfer;
            tag_id[0] <= winner;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (transfer) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    // The multiplier has no reset, so its output is only trusted alongside a valid tag.
    assign rsp_valid = tag_v[PIPE_STAGES-1];
    assign rsp_id    = rsp_valid ? tag_id[PIPE_STAGES-1] : '0;
    assign rsp_data  = rsp_valid ? mul_result : '0;
    assign busy      = |tag_v;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: pipelined multiplier stand-in, queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_rr_scheduler;
    localparam int WIDTH = 16;
    localparam int PIPE  = 2;
    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int PW    = 2 * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WIDTH-1:0] req_a;
    logic [N*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]  mul_a;
    logic [WIDTH-1:0]  mul_b;
    logic [PW-1:0]     mul_result;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [PW-1:0]     rsp_data;
    logic              busy;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    // Multiplier stand-in: PIPE-deep product register chain, no reset.
    logic [PW-1:0] pipe_q [PIPE];
    always @(posedge clk) begin
        for (int k = PIPE - 1; k > 0; k--) pipe_q[k] <= pipe_q[k-1];
        pipe_q[0] <= PW'(mul_a) * PW'(mul_b);
    end
    assign mul_result = pipe_q[PIPE-1];

    // Requester-side state
    logic [N-1:0]     vld;
    logic [WIDTH-1:0] op_a [N];
    logic [WIDTH-1:0] op_b [N];
    always_comb begin
        req_valid = vld;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    // Reference model state
    int            m_ptr;
    int            cyc;
    int            m_win;
    bit            m_xfer;
    logic [PW-1:0] exp_q[$];
    int            id_q[$];
    int            due_q[$];

    // Observation logs for directed scenarios
    int            grant_log[$];
    int            rsp_id_log[$];
    logic [PW-1:0] rsp_data_log[$];
    int            rsp_cyc_log[$];
    int            busy_cnt;
    int            ready_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_id_log.delete();
        rsp_data_log.delete();
        rsp_cyc_log.delete();
        busy_cnt  = 0;
        ready_cnt = 0;
    endtask

    // One clock cycle: compare at negedge, advance the model at posedge, return 1ns later.
    task automatic step();
        logic [N-1:0]     e_ready;
        logic [WIDTH-1:0] e_a;
        logic [WIDTH-1:0] e_b;
        bit               e_rv;
        int               e_id;
        logic [PW-1:0]    e_data;
        bit               hs;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            id_q.delete();
            due_q.delete();
            m_ptr = 0;
        end
        m_win = -1;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (m_ptr + off) % N;
            if (m_win < 0 && vld[idx]) m_win = idx;
        end
        hs     = en && (m_win >= 0);
        m_xfer = hs && !rst;
        e_ready = hs ? (N'(1) << m_win) : '0;
        e_a = hs ? op_a[m_win] : '0;
        e_b = hs ? op_b[m_win] : '0;
        e_rv = (due_q.size() > 0) && (due_q[0] == cyc);
        e_id   = e_rv ? id_q[0] : 0;
        e_data = e_rv ? exp_q[0] : '0;
        check("req_ready", req_ready, e_ready);
        check("mul_a", mul_a, e_a);
        check("mul_b", mul_b, e_b);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_id", rsp_id, e_id);
        check("rsp_data", rsp_data, e_data);
        check("busy", busy, exp_q.size() > 0);
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        if (rsp_valid) begin
            rsp_id_log.push_back(rsp_id);
            rsp_data_log.push_back(rsp_data);
            rsp_cyc_log.push_back(cyc);
        end
        busy_cnt  += busy;
        ready_cnt += (req_ready != 0);
        @(posedge clk);
        if (!rst) begin
            if (e_rv) begin
                void'(exp_q.pop_front());
                void'(id_q.pop_front());
                void'(due_q.pop_front());
            end
            if (m_xfer) begin
                exp_q.push_back(PW'(op_a[m_win]) * PW'(op_b[m_win]));
                id_q.push_back(m_win);
                due_q.push_back(cyc + PIPE);
                m_ptr = (m_win + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic load(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vld[i]  = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    int t0;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        vld = '0;
        cyc = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        #1;

        // Reset held with random requests and enable
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            vld = N'($urandom);
            en  = 1'($urandom);
            step();
        end
        check("reset_busy_cycles", busy_cnt, 0);
        check("reset_rsp_count", rsp_cyc_log.size(), 0);
        vld = '0;
        en  = 1'b1;
        rst = 1'b0;

        // Single requester: 3*7 from requester 2
        do_reset();
        clear_logs();
        load(2, 16'd3, 16'd7);
        t0 = cyc;
        step();
        vld[2] = 1'b0;
        repeat (5) step();
        check("single_rsp_count", rsp_cyc_log.size(), 1);
        if (rsp_cyc_log.size() > 0) begin
            check("single_latency", rsp_cyc_log[0] - t0, 2);
            check("single_id", rsp_id_log[0], 2);
            check("single_data", rsp_data_log[0], 32'd21);
        end
        check("single_busy_cycles", busy_cnt, 2);

        // Fairness: all requesters valid continuously
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) load(i, rand_op(), rand_op());
        repeat (12) begin
            step();
            if (m_xfer) load(m_win, rand_op(), rand_op());
        end
        vld = '0;
        repeat (4) step();
        check("fair_grant_count", grant_log.size(), 12);
        check("fair_rsp_count", rsp_id_log.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < grant_log.size()) check("fair_grant_order", grant_log[k], k % N);
            if (k < rsp_id_log.size()) check("fair_rsp_order", rsp_id_log[k], k % N);
        end

        // Wrap and skip: pointer at 3, only req 1 valid; then req 0 and 3 compete
        do_reset();
        load(2, 16'd1, 16'd1);
        step();
        vld = '0;
        clear_logs();
        load(1, 16'd5, 16'd6);
        step();
        vld[1] = 1'b0;
        load(0, 16'd2, 16'd2);
        load(3, 16'd4, 16'd4);
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        vld = '0;
        repeat (3) step();
        check("wrap_grant_count", grant_log.size(), 3);
        if (grant_log.size() >= 3) begin
            check("wrap_first", grant_log[0], 1);
            check("wrap_skip", grant_log[1], 3);
            check("wrap_third", grant_log[2], 0);
        end

        // Boundary operands
        clear_logs();
        load(0, 16'hFFFF, 16'hFFFF);
        step();
        vld[0] = 1'b0;
        load(1, 16'h0000, 16'h1234);
        step();
        vld[1] = 1'b0;
        repeat (4) step();
        check("bound_rsp_count", rsp_data_log.size(), 2);
        if (rsp_data_log.size() >= 2) begin
            check("bound_max", rsp_data_log[0], 32'hFFFE_0001);
            check("bound_zero", rsp_data_log[1], 32'h0);
            check("bound_id1", rsp_id_log[1], 1);
        end

        // Reset with two ops in flight
        load(0, 16'd9, 16'd9);
        load(1, 16'd8, 16'd8);
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        vld = '0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
        repeat (5) step();
        check("rst_flight_rsp_count", rsp_cyc_log.size(), 0);
        check("rst_flight_busy", busy_cnt, 0);

        // en=0 while busy: drain continues, no new grants
        load(2, 16'd11, 16'd3);
        load(3, 16'd12, 16'd5);
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        en = 1'b0;
        load(0, 16'd7, 16'd7);
        clear_logs();
        repeat (4) step();
        check("drain_rsp_count", rsp_data_log.size(), 2);
        if (rsp_data_log.size() >= 2) begin
            check("drain_data0", rsp_data_log[0], 32'd33);
            check("drain_data1", rsp_data_log[1], 32'd60);
        end
        check("drain_no_ready", ready_cnt, 0);
        en = 1'b1;
        clear_logs();
        step();
        if (m_xfer) vld[m_win] = 1'b0;
        check("drain_regrant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) check("drain_regrant_id", grant_log[0], 0);
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) load(i, rand_op(), rand_op());
            end
            step();
            if (m_xfer) vld[m_win] = 1'b0;
        end
        rst = 1'b0;
        vld = '0;
        repeat (PIPE + 2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
